carpma_hakemi: RTL and testbench

Round-robin arbiter and sequencer that shares the single pipelined multiply unit between two requesters in the execute stage: port 0 (core MUL/MULH/MULHSU/MULHU micro-ops) and port 1 (AI accelerator convolution MACs). It registers the granted operands toward the multiplier and carries a tag pipeline matched to the multiplier latency. Each result goes back to the requester that issued it as a one-cycle pulse. It honours the global stall and an accelerator-driven flush.

---
 rtl/carpma_hakemi_if.sv | 34 +++
 rtl/carpma_hakemi.sv | 76 +++++++
 tb/tb_carpma_hakemi.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/carpma_hakemi_if.sv
// carpma_hakemi_if: request, multiplier and per-port result signals of the shared multiply arbiter
interface carpma_hakemi_if #(
    parameter int VERI_BIT = 32
);
    logic                cek0_gecerli_i, cek1_gecerli_i;
    logic                cek0_hazir_o, cek1_hazir_o;
    logic [1:0]          cek0_islem_i, cek1_islem_i;
    logic [VERI_BIT-1:0] cek0_deger1_i, cek0_deger2_i, cek1_deger1_i, cek1_deger2_i;
    logic                carp_gecerli_o;
    logic [1:0]          carp_islem_o;
    logic [VERI_BIT-1:0] carp_deger1_o, carp_deger2_o;
    logic [VERI_BIT-1:0] carp_sonuc_i;
    logic                sonuc0_gecerli_o, sonuc1_gecerli_o;
    logic [VERI_BIT-1:0] sonuc0_o, sonuc1_o;
    logic                mesgul_o;

    modport slave (
        input  cek0_gecerli_i, cek1_gecerli_i, cek0_islem_i, cek1_islem_i,
        input  cek0_deger1_i, cek0_deger2_i, cek1_deger1_i, cek1_deger2_i,
        input  carp_sonuc_i,
        output cek0_hazir_o, cek1_hazir_o,
        output carp_gecerli_o, carp_islem_o, carp_deger1_o, carp_deger2_o,
        output sonuc0_gecerli_o, sonuc1_gecerli_o, sonuc0_o, sonuc1_o, mesgul_o
    );

    modport master (
        output cek0_gecerli_i, cek1_gecerli_i, cek0_islem_i, cek1_islem_i,
        output cek0_deger1_i, cek0_deger2_i, cek1_deger1_i, cek1_deger2_i,
        output carp_sonuc_i,
        input  cek0_hazir_o, cek1_hazir_o,
        input  carp_gecerli_o, carp_islem_o, carp_deger1_o, carp_deger2_o,
        input  sonuc0_gecerli_o, sonuc1_gecerli_o, sonuc0_o, sonuc1_o, mesgul_o
    );
endinterface

// File: rtl/carpma_hakemi.sv
// carpma_hakemi: round-robin arbiter sharing one pipelined multiplier between core and accelerator,
// with a latency-matched tag pipeline routing each result back to its issuing port.
module carpma_hakemi #(
    parameter int GECIKME  = 3,
    parameter int VERI_BIT = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           durdur_i,
    input  logic           temizle_i,
    carpma_hakemi_if.slave b
);
    logic                son_izin, port_r, sec1, acik, h0, h1, kabul;
    logic                carp_v, s0_v, s1_v, cik_v, cik_p;
    logic [1:0]          carp_op;
    logic [VERI_BIT-1:0] carp_d1, carp_d2, s0, s1;
    logic [GECIKME-1:0]  tag_v, tag_p;

    assign acik  = rst_ni & ~durdur_i & ~temizle_i;
    // under contention the port that did not win last time is granted
    assign sec1  = b.cek1_gecerli_i & (~b.cek0_gecerli_i | ~son_izin);
    assign h0    = acik & b.cek0_gecerli_i & ~sec1;
    assign h1    = acik & sec1;
    assign kabul = h0 | h1;
    assign cik_v = tag_v[GECIKME-1];
    assign cik_p = tag_p[GECIKME-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            son_izin <= 1'b1;
            port_r   <= 1'b0;
            carp_v   <= 1'b0;
            carp_op  <= '0;
            carp_d1  <= '0;
            carp_d2  <= '0;
            tag_v    <= '0;
            tag_p    <= '0;
            s0_v     <= 1'b0;
            s1_v     <= 1'b0;
            s0       <= '0;
            s1       <= '0;
        end else if (temizle_i) begin
            carp_v <= 1'b0;
            tag_v  <= '0;
            s0_v   <= 1'b0;
            s1_v   <= 1'b0;
        end else if (!durdur_i) begin
            carp_v <= kabul;
            if (kabul) begin
                son_izin <= sec1;
                port_r   <= sec1;
                carp_op  <= sec1 ? b.cek1_islem_i  : b.cek0_islem_i;
                carp_d1  <= sec1 ? b.cek1_deger1_i : b.cek0_deger1_i;
                carp_d2  <= sec1 ? b.cek1_deger2_i : b.cek0_deger2_i;
            end
            tag_v <= GECIKME'({tag_v, carp_v});
            tag_p <= GECIKME'({tag_p, port_r});
            s0_v  <= cik_v & ~cik_p;
            s1_v  <= cik_v & cik_p;
            if (cik_v & ~cik_p) s0 <= b.carp_sonuc_i;
            if (cik_v & cik_p) s1 <= b.carp_sonuc_i;
        end
    end

    assign b.cek0_hazir_o     = h0;
    assign b.cek1_hazir_o     = h1;
    assign b.carp_gecerli_o   = carp_v;
    assign b.carp_islem_o     = carp_op;
    assign b.carp_deger1_o    = carp_d1;
    assign b.carp_deger2_o    = carp_d2;
    assign b.sonuc0_gecerli_o = s0_v;
    assign b.sonuc1_gecerli_o = s1_v;
    assign b.sonuc0_o         = s0;
    assign b.sonuc1_o         = s1;
    assign b.mesgul_o         = carp_v | (|tag_v);
endmodule

// File: tb/tb_carpma_hakemi.sv
// tb_carpma_hakemi: vector table plus hand sequences for stall, flush, reset and contention,
// with a result scoreboard fed at acceptance and drained at each result pulse.
module tb_carpma_hakemi;
    localparam int G = 3;
    localparam int W = 32;

    typedef struct {
        bit         p;
        logic [1:0] op;
        logic [W-1:0] a, c, e;
    } vec_t;

    typedef struct {
        bit         p;
        logic [W-1:0] v;
    } bek_t;

    logic clk_i = 1'b0, rst_ni = 1'b0, durdur_i = 1'b0, temizle_i = 1'b0;
    logic [W-1:0] mp [G];
    logic [W-1:0] e0, e1;
    int cnt = 0, checks = 0, errors = 0, plast = 0;
    int pcnt [2];
    bek_t q [$];
    vec_t tv [8];

    carpma_hakemi_if #(.VERI_BIT(W)) b ();
    carpma_hakemi #(.GECIKME(G), .VERI_BIT(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .durdur_i(durdur_i), .temizle_i(temizle_i), .b(b)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cnt <= cnt + 1;

    function automatic logic [W-1:0] mul_f(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] c);
        logic signed [W:0] x, y;
        logic signed [2*W+1:0] r;
        x = {(op == 2'd1 || op == 2'd2) & a[W-1], a};
        y = {(op == 2'd1) & c[W-1], c};
        r = x * y;
        return (op == 2'd0) ? r[W-1:0] : r[2*W-1:W];
    endfunction

    // environment multiplier: fixed latency, frozen by the same stall
    always @(posedge clk_i) if (!durdur_i) begin
        mp[0] <= mul_f(b.carp_islem_o, b.carp_deger1_o, b.carp_deger2_o);
        for (int i = 1; i < G; i++) mp[i] <= mp[i-1];
    end
    assign b.carp_sonuc_i = mp[G-1];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cnt);
        end
    endtask

    task automatic pop_chk(input bit p, input logic [W-1:0] v);
        bek_t e;
        pcnt[p]++;
        plast = cnt;
        chk("pulse_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("result_port", p, e.p);
            chk("result_value", v, e.v);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_ni) q.delete();
        else begin
            if (!durdur_i && b.sonuc0_gecerli_o) pop_chk(1'b0, b.sonuc0_o);
            if (!durdur_i && b.sonuc1_gecerli_o) pop_chk(1'b1, b.sonuc1_o);
            if (temizle_i) q.delete();
            if (b.cek0_gecerli_i && b.cek0_hazir_o) q.push_back('{1'b0, e0});
            if (b.cek1_gecerli_i && b.cek1_hazir_o) q.push_back('{1'b1, e1});
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input bit p, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] c, input logic [W-1:0] e);
        if (p) begin
            b.cek1_gecerli_i = 1'b1; b.cek1_islem_i = op; b.cek1_deger1_i = a; b.cek1_deger2_i = c; e1 = e;
        end else begin
            b.cek0_gecerli_i = 1'b1; b.cek0_islem_i = op; b.cek0_deger1_i = a; b.cek0_deger2_i = c; e0 = e;
        end
    endtask

    task automatic idle();
        b.cek0_gecerli_i = 1'b0;
        b.cek1_gecerli_i = 1'b0;
    endtask

    task automatic drain(input int n);
        int k = 0;
        while (q.size() != 0 && k < n) begin
            cyc();
            k++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int a, s0, s1, tot;
        tv[0] = '{1'b0, 2'd0, 32'd7,        32'd6,        32'd42};
        tv[1] = '{1'b1, 2'd0, 32'd3,        32'd3,        32'd9};
        tv[2] = '{1'b0, 2'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        tv[3] = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        tv[4] = '{1'b0, 2'd3, 32'hFFFFFFFF, 32'd2,        32'h00000001};
        tv[5] = '{1'b1, 2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
        tv[6] = '{1'b0, 2'd2, 32'h80000000, 32'h80000000, 32'hC0000000};
        tv[7] = '{1'b1, 2'd0, 32'h00010000, 32'h00010000, 32'h00000000};
        pcnt[0] = 0; pcnt[1] = 0;
        e0 = '0; e1 = '0;
        b.cek0_islem_i = '0; b.cek1_islem_i = '0;
        b.cek0_deger1_i = '0; b.cek0_deger2_i = '0; b.cek1_deger1_i = '0; b.cek1_deger2_i = '0;
        b.cek0_gecerli_i = 1'b1; b.cek1_gecerli_i = 1'b1;
        #2;
        chk("reset_outputs", |{b.carp_gecerli_o, b.carp_islem_o, b.carp_deger1_o, b.carp_deger2_o,
            b.sonuc0_gecerli_o, b.sonuc1_gecerli_o, b.sonuc0_o, b.sonuc1_o, b.mesgul_o,
            b.cek0_hazir_o, b.cek1_hazir_o}, 0);
        idle();
        #21 rst_ni = 1'b1;

        for (int i = 0; i < 8; i++) begin
            s0 = pcnt[0]; s1 = pcnt[1];
            cyc();
            req(tv[i].p, tv[i].op, tv[i].a, tv[i].c, tv[i].e);
            @(negedge clk_i);
            chk("vec_accept", tv[i].p ? b.cek1_hazir_o : b.cek0_hazir_o, 1);
            a = cnt;
            cyc();
            chk("vec_issue_valid", b.carp_gecerli_o, 1);
            idle();
            drain(20);
            chk("vec_latency", plast, a + G + 2);
            chk("vec_port0_pulses", pcnt[0], s0 + (tv[i].p ? 0 : 1));
            chk("vec_port1_pulses", pcnt[1], s1 + (tv[i].p ? 1 : 0));
        end

        s1 = pcnt[1];
        cyc();
        req(1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("stream_accept", b.cek1_hazir_o, 1);
            if (i == 0) a = cnt;
            cyc();
        end
        idle();
        drain(20);
        chk("stream_pulses", pcnt[1], s1 + 4);
        chk("stream_last", plast, a + 3 + G + 2);

        tot = pcnt[0] + pcnt[1];
        cyc();
        req(1'b0, 2'd0, 32'd11, 32'd3, 32'd33);
        @(negedge clk_i);
        a = cnt;
        cyc();
        idle();
        cyc();
        for (int i = 0; i < 3; i++) begin
            durdur_i = 1'b1;
            req(1'b0, 2'd0, 32'd1, 32'd1, 32'd1);
            @(negedge clk_i);
            chk("stall_hazir", b.cek0_hazir_o, 0);
            cyc();
        end
        durdur_i = 1'b0;
        idle();
        drain(20);
        chk("stall_latency", plast, a + G + 2 + 3);
        chk("stall_once", pcnt[0] + pcnt[1], tot + 1);

        tot = pcnt[0] + pcnt[1];
        cyc();
        req(1'b0, 2'd0, 32'd4, 32'd4, 32'd16);
        @(negedge clk_i);
        a = cnt;
        cyc();
        idle();
        req(1'b1, 2'd0, 32'd5, 32'd5, 32'd25);
        cyc();
        idle();
        cyc();
        temizle_i = 1'b1;
        cyc();
        temizle_i = 1'b0;
        chk("flush_mesgul", b.mesgul_o, 0);
        req(1'b0, 2'd0, 32'd7, 32'd6, 32'd42);
        @(negedge clk_i);
        chk("flush_next_accept", b.cek0_hazir_o, 1);
        cyc();
        idle();
        drain(20);
        chk("flush_new_latency", plast, a + 4 + G + 2);
        chk("flush_dropped", pcnt[0] + pcnt[1], tot + 1);

        tot = pcnt[0] + pcnt[1];
        cyc();
        req(1'b0, 2'd0, 32'd9, 32'd9, 32'd81);
        cyc();
        cyc();
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_reset_outputs", |{b.carp_gecerli_o, b.carp_deger1_o, b.sonuc0_gecerli_o,
            b.sonuc1_gecerli_o, b.sonuc0_o, b.sonuc1_o, b.mesgul_o, b.cek0_hazir_o}, 0);
        idle();
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        for (int i = 0; i < 12; i++) cyc();
        chk("reset_no_stale", pcnt[0] + pcnt[1], tot);
        chk("reset_idle", b.mesgul_o, 0);

        s0 = pcnt[0]; s1 = pcnt[1];
        cyc();
        req(1'b0, 2'd0, 32'd2, 32'd5, 32'd10);
        req(1'b1, 2'd0, 32'd3, 32'd3, 32'd9);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            chk("grant_port0", b.cek0_hazir_o, (i % 2) == 0);
            chk("grant_port1", b.cek1_hazir_o, (i % 2) == 1);
            cyc();
        end
        idle();
        drain(30);
        chk("contend_port0", pcnt[0], s0 + 3);
        chk("contend_port1", pcnt[1], s1 + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
